axis_framer: RTL and testbench
==============================

# axis_framer

AXI-Stream framer that sits directly downstream of the `fifo` stage in the transmit path. It consumes the FIFO's continuous payload stream and emits fixed-length frames. Each frame is a sync word, then a 16-bit frame sequence number, then `LENGTH` payload words, with `m_axis_tlast` on the final payload word. Output is fully registered, so the framer can drive a downstream `fifo` or serializer directly.

## Interface
- `WIDTH`, 32, data width in bits; must be ≥ 16.
- `LENGTH`, 8, payload words per frame; must be ≥ 1.
- `SYNC`, 32'h1ACFFC1D, sync word; the low `WIDTH` bits are used.
- `aclk`  in  1  clock; all logic on the rising edge.
- `areset`  in  1  reset; asynchronous, active-high.
- `s_axis_tdata`  in  WIDTH  payload from the upstream FIFO.
- `s_axis_tvalid`  in  1  upstream data valid.
- `s_axis_tready`  out  1  framer accepts payload.
- `m_axis_tdata`  out  WIDTH  framed output word.
- `m_axis_tvalid`  out  1  output word valid.
- `m_axis_tready`  in  1  downstream accepts.
- `m_axis_tlast`  out  1  last word of frame.

## Operation
- A single output register holds `m_axis_tdata`, `m_axis_tlast` and `m_axis_tvalid`.
- `free` = `~m_axis_tvalid | m_axis_tready`. The register loads only when `free` is high.
- A transfer occurs when valid and ready are both high on a rising edge.
- FSM states and transitions:
  - IDLE → SEQ: when `s_axis_tvalid & free`. Load `SYNC`, tlast=0.
  - SEQ → PAYLOAD: when `free`. Load `{{WIDTH-16{1'b0}}, seq}`, tlast=0.
  - PAYLOAD: `s_axis_tready = free`. On an input transfer, load `s_axis_tdata` and increment `cnt`.
    - If `cnt == LENGTH-1`: set tlast=1, clear `cnt` to 0, increment `seq` (wraps 16'hFFFF → 0), go to IDLE.
- `s_axis_tready` is 0 in IDLE and SEQ. A frame therefore never starts until at least one payload word is pending.
- Once a frame starts it always completes. Upstream gaps in PAYLOAD only stall the frame; no padding is inserted.
- When `free` is low, the output register and the FSM hold.
- `tdata`, `tlast` and `tvalid` are stable while `tvalid` is high and `m_axis_tready` is low (AXI-Stream rule).
- Width rules:
  - `cnt` is `$clog2(LENGTH+1)` bits.
  - `seq` is 16 bits, zero-extended to `WIDTH`.
  - `SYNC` is truncated to `WIDTH`.

## Timing
- Reset values:
  - `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `s_axis_tready`=0.
  - FSM=IDLE, `cnt`=0, `seq`=0.
- `areset` asserted mid-frame clears all state immediately. The partial frame is abandoned and the output word is dropped. The next frame starts with `seq`=0.
- Latency: `s_axis_tvalid` rising in IDLE gives the SYNC word valid at the next edge. The first payload word appears at edge +3 when `m_axis_tready` is held high.
- Throughput:
  - With `m_axis_tready` held high and input always valid, output is one word per cycle with no bubbles.
  - The frame takes `LENGTH+2` cycles, and input efficiency is `LENGTH/(LENGTH+2)`.
- `s_axis_tready` is combinational from `m_axis_tready`, FSM state and `m_axis_tvalid`. There is no combinational path from `s_axis_tvalid` to `s_axis_tready`.
- Back-to-back frames: IDLE is left on the cycle after the tlast load, as long as `free` is high and input is valid. There are no dead cycles between frames.

## Test plan
- Reset check, `LENGTH`=4, `WIDTH`=32:
  - Stimulus: hold `areset` for 3 cycles with `s_axis_tvalid`=1.
  - Required: `m_axis_tvalid`=0 and `s_axis_tready`=0 throughout.
  - Required after release: the first output is 32'h1ACFFC1D.
- Single frame:
  - Stimulus: send 0,1,2,3 with `m_axis_tready`=1.
  - Required output: 1ACFFC1D, 0, 0, 1, 2, 3 on 6 consecutive cycles, with tlast only on word 3.
- Back-to-back frames:
  - Stimulus: 12 words 0..11 streamed continuously.
  - Required: three frames with seq 0, 1, 2, tlast on 3, 7 and 11, and 18 consecutive valid cycles.
- Backpressure:
  - Stimulus: toggle `m_axis_tready` pseudo-randomly during a frame.
  - Required: output words are held stable while stalled, with no loss or duplication.
  - Required: `s_axis_tready`=0 whenever `m_axis_tvalid`=1 and `m_axis_tready`=0.
- Chained with `fifo` (DEPTH=5):
  - Stimulus: fill the FIFO with 0..4 with the framer output stalled, then release.
  - Required: sync, seq, 0..3 (tlast on 3), then sync, seq 1, and word 4 waiting in PAYLOAD with tlast=0.
- Mid-frame reset and seq wrap:
  - Stimulus: assert `areset` after 2 payload words.
  - Required: `m_axis_tvalid`=0 in the same cycle, and the next frame carries seq=0.
  - Stimulus: force 65536 frames.
  - Required: seq wraps 16'hFFFF → 0.

Source files
------------

// File: rtl/axis_framer.sv
// AXI-Stream framer: wraps a continuous payload stream into frames of
// SYNC word, 16-bit sequence number, then LENGTH payload words (tlast on the last).
module axis_framer #(
   parameter int          WIDTH  = 32,
   parameter int          LENGTH = 8,
   parameter logic [31:0] SYNC   = 32'h1ACFFC1D
) (
   input  logic             aclk,
   input  logic             areset,
   input  logic [WIDTH-1:0] s_axis_tdata,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   output logic [WIDTH-1:0] m_axis_tdata,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic             m_axis_tlast
);
   localparam int               CNT_W     = $clog2(LENGTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LENGTH - 1);
   localparam logic [WIDTH-1:0] SYNC_WORD = WIDTH'(SYNC);

   typedef enum logic [1:0] {IDLE, SEQ, PAYLOAD} state_t;

   state_t           state, next_state;
   logic [CNT_W-1:0] cnt, next_cnt;
   logic [15:0]      seq, next_seq;
   logic [WIDTH-1:0] next_data;
   logic             next_valid, next_last;
   logic             free;

   // The output register can take a new word when it is empty or being drained.
   assign free          = ~m_axis_tvalid | m_axis_tready;
   assign s_axis_tready = (state == PAYLOAD) & free;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state         <= IDLE;
         cnt           <= '0;
         seq           <= '0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
      end else begin
         state         <= next_state;
         cnt           <= next_cnt;
         seq           <= next_seq;
         m_axis_tdata  <= next_data;
         m_axis_tvalid <= next_valid;
         m_axis_tlast  <= next_last;
      end
   end

   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      next_seq   = seq;
      next_data  = m_axis_tdata;
      next_valid = m_axis_tvalid;
      next_last  = m_axis_tlast;
      if (free) begin
         // Register drains unless a new word is loaded this cycle.
         next_valid = 1'b0;
         next_last  = 1'b0;
         case (state)
            IDLE: begin
               if (s_axis_tvalid) begin
                  next_data  = SYNC_WORD;
                  next_valid = 1'b1;
                  next_state = SEQ;
               end
            end
            SEQ: begin
               next_data  = WIDTH'(seq);
               next_valid = 1'b1;
               next_state = PAYLOAD;
            end
            PAYLOAD: begin
               if (s_axis_tvalid) begin
                  next_data  = s_axis_tdata;
                  next_valid = 1'b1;
                  if (cnt == CNT_LAST) begin
                     next_last  = 1'b1;
                     next_cnt   = '0;
                     next_seq   = seq + 16'd1;
                     next_state = IDLE;
                  end else begin
                     next_cnt = cnt + 1'b1;
                  end
               end
            end
            default: next_state = IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axis_framer.sv
// Self-checking bench for axis_framer (WIDTH=32, LENGTH=4): randomized streams
// compared against a frame-level reference model, plus cycle-exact scenarios.
module tb_axis_framer;
   localparam int          WIDTH  = 32;
   localparam int          LENGTH = 4;
   localparam logic [31:0] SYNC   = 32'h1ACFFC1D;

   logic             aclk = 1'b0;
   logic             areset;
   logic [WIDTH-1:0] s_axis_tdata;
   logic             s_axis_tvalid;
   logic             s_axis_tready;
   logic [WIDTH-1:0] m_axis_tdata;
   logic             m_axis_tvalid;
   logic             m_axis_tready;
   logic             m_axis_tlast;

   int vectors     = 0;
   int miscompares = 0;

   logic [WIDTH:0] exp_q[$];
   logic [WIDTH:0] got_q[$];
   int             got_cyc[$];
   logic [15:0]    model_seq;

   axis_framer #(
      .WIDTH (WIDTH),
      .LENGTH(LENGTH),
      .SYNC  (SYNC)
   ) dut (
      .aclk         (aclk),
      .areset       (areset),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tlast (m_axis_tlast)
   );

   always #5 aclk = ~aclk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish, required finish before time 500000");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic do_reset();
      areset        = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      m_axis_tready = 1'b0;
      repeat (2) @(posedge aclk);
      #1 areset = 1'b0;
      model_seq = 16'h0;
      exp_q.delete();
   endtask

   // Reference: each group of LENGTH input words becomes SYNC, seq, words.
   task automatic model_push(input logic [WIDTH-1:0] w[$]);
      for (int i = 0; i < w.size(); i++) begin
         if (i % LENGTH == 0) begin
            exp_q.push_back({1'b0, SYNC});
            exp_q.push_back({1'b0, 16'h0, model_seq});
         end
         exp_q.push_back({(i % LENGTH) == LENGTH - 1, w[i]});
         if ((i % LENGTH) == LENGTH - 1) model_seq = model_seq + 16'd1;
      end
   endtask

   task automatic run_stream(input logic [WIDTH-1:0] w[$], input int vpct,
                             input int rpct, input int max_cycles);
      int             idx     = 0;
      int             cyc     = 0;
      logic           stalled = 1'b0;
      logic [WIDTH:0] held    = '0;
      got_q.delete();
      got_cyc.delete();
      while ((idx < w.size() || m_axis_tvalid) && cyc < max_cycles) begin
         if (stalled) begin
            vectors++;
            if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, held}) begin
               miscompares++;
               $display("[TB] FAIL stall_hold: got valid=%b last=%b data=%h, required valid=1 last=%b data=%h",
                        m_axis_tvalid, m_axis_tlast, m_axis_tdata, held[WIDTH], held[WIDTH-1:0]);
            end
         end
         s_axis_tvalid = (idx < w.size()) && (int'($urandom_range(0, 99)) < vpct);
         if (s_axis_tvalid) s_axis_tdata = w[idx];
         else               s_axis_tdata = WIDTH'($urandom);
         m_axis_tready = int'($urandom_range(0, 99)) < rpct;
         #1;
         if (m_axis_tvalid && !m_axis_tready) begin
            vectors++;
            if (s_axis_tready !== 1'b0) begin
               miscompares++;
               $display("[TB] FAIL s_ready_stall: got s_axis_tready=%b, required 0", s_axis_tready);
            end
         end
         if (m_axis_tvalid && m_axis_tready) begin
            got_q.push_back({m_axis_tlast, m_axis_tdata});
            got_cyc.push_back(cyc);
         end
         if (s_axis_tvalid && s_axis_tready) idx++;
         stalled = m_axis_tvalid && !m_axis_tready;
         held    = {m_axis_tlast, m_axis_tdata};
         @(posedge aclk);
         #1;
         cyc++;
      end
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b0;
      vectors++;
      if (cyc >= max_cycles) begin
         miscompares++;
         $display("[TB] FAIL stream_timeout: got %0d of %0d words accepted after %0d cycles, required all",
                  idx, w.size(), cyc);
      end
   endtask

   task automatic test_reset();
      areset        = 1'b1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'h5A5A0001;
      m_axis_tready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge aclk);
         #1;
         vectors++;
         if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, s_axis_tready} !== {2'b00, 32'h0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_hold: got valid=%b last=%b data=%h s_ready=%b, required all zero",
                     m_axis_tvalid, m_axis_tlast, m_axis_tdata, s_axis_tready);
         end
      end
      areset = 1'b0;
      @(posedge aclk);
      #1;
      vectors++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {2'b10, SYNC}) begin
         miscompares++;
         $display("[TB] FAIL reset_first_word: got valid=%b last=%b data=%h, required valid=1 last=0 data=%h",
                  m_axis_tvalid, m_axis_tlast, m_axis_tdata, SYNC);
      end
   endtask

   task automatic test_single_frame();
      logic [WIDTH-1:0] w[$];
      do_reset();
      for (int i = 0; i < LENGTH; i++) w.push_back(WIDTH'(i));
      model_push(w);
      run_stream(w, 100, 100, 50);
      vectors++;
      if (got_q.size() != exp_q.size()) begin
         miscompares++;
         $display("[TB] FAIL single_count: got %0d words, required %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         vectors++;
         if (got_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("[TB] FAIL single_word[%0d]: got last=%b data=%h, required last=%b data=%h",
                     i, got_q[i][WIDTH], got_q[i][WIDTH-1:0], exp_q[i][WIDTH], exp_q[i][WIDTH-1:0]);
         end
      end
      if (got_cyc.size() == LENGTH + 2) begin
         vectors++;
         if (got_cyc[0] != 1 || got_cyc[LENGTH+1] - got_cyc[0] != LENGTH + 1) begin
            miscompares++;
            $display("[TB] FAIL single_timing: got first=%0d span=%0d, required first=1 span=%0d",
                     got_cyc[0], got_cyc[LENGTH+1] - got_cyc[0], LENGTH + 1);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] w[$];
      do_reset();
      for (int i = 0; i < 3 * LENGTH; i++) w.push_back(WIDTH'(i));
      model_push(w);
      run_stream(w, 100, 100, 100);
      vectors++;
      if (got_q.size() != 3 * (LENGTH + 2)) begin
         miscompares++;
         $display("[TB] FAIL b2b_count: got %0d words, required %0d", got_q.size(), 3 * (LENGTH + 2));
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         vectors++;
         if (got_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("[TB] FAIL b2b_word[%0d]: got last=%b data=%h, required last=%b data=%h",
                     i, got_q[i][WIDTH], got_q[i][WIDTH-1:0], exp_q[i][WIDTH], exp_q[i][WIDTH-1:0]);
         end
      end
      if (got_cyc.size() == 3 * (LENGTH + 2)) begin
         vectors++;
         if (got_cyc[0] != 1 || got_cyc[3*(LENGTH+2)-1] - got_cyc[0] != 3 * (LENGTH + 2) - 1) begin
            miscompares++;
            $display("[TB] FAIL b2b_no_bubbles: got first=%0d span=%0d, required first=1 span=%0d",
                     got_cyc[0], got_cyc[3*(LENGTH+2)-1] - got_cyc[0], 3 * (LENGTH + 2) - 1);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [WIDTH-1:0] w[$];
      int               vp;
      int               rp;
      int               frames;
      do_reset();
      for (int r = 0; r < 3; r++) begin
         vp     = (r == 0) ? 100 : 50 + 20 * r;
         rp     = (r == 2) ? 30 : 50 + 10 * r;
         frames = 5 + r;
         w.delete();
         exp_q.delete();
         for (int i = 0; i < frames * LENGTH; i++) w.push_back(WIDTH'($urandom));
         model_push(w);
         run_stream(w, vp, rp, 3000);
         vectors++;
         if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("[TB] FAIL bp_count[%0d]: got %0d words, required %0d", r, got_q.size(), exp_q.size());
         end
         for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
               miscompares++;
               $display("[TB] FAIL bp_word[%0d.%0d]: got last=%b data=%h, required last=%b data=%h",
                        r, i, got_q[i][WIDTH], got_q[i][WIDTH-1:0], exp_q[i][WIDTH], exp_q[i][WIDTH-1:0]);
            end
         end
      end
   endtask

   // Upstream is a behavioural DEPTH=5 FIFO; the framer output is stalled while it fills.
   task automatic test_chained_fifo();
      logic [WIDTH-1:0] fifo[$];
      logic [WIDTH-1:0] w[$];
      int               pushed = 0;
      do_reset();
      got_q.delete();
      for (int i = 0; i < 5; i++) w.push_back(WIDTH'(i));
      model_push(w);
      for (int cyc = 0; cyc < 40; cyc++) begin
         s_axis_tvalid = fifo.size() > 0;
         s_axis_tdata  = (fifo.size() > 0) ? fifo[0] : '0;
         m_axis_tready = cyc >= 8;
         #1;
         if (m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tlast, m_axis_tdata});
         if (s_axis_tvalid && s_axis_tready) void'(fifo.pop_front());
         if (pushed < 5 && fifo.size() < 5) begin
            fifo.push_back(WIDTH'(pushed));
            pushed++;
         end
         @(posedge aclk);
         #1;
      end
      vectors++;
      if (got_q.size() != exp_q.size()) begin
         miscompares++;
         $display("[TB] FAIL fifo_count: got %0d words, required %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         vectors++;
         if (got_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("[TB] FAIL fifo_word[%0d]: got last=%b data=%h, required last=%b data=%h",
                     i, got_q[i][WIDTH], got_q[i][WIDTH-1:0], exp_q[i][WIDTH], exp_q[i][WIDTH-1:0]);
         end
      end
      s_axis_tvalid = 1'b0;
      #1;
      vectors++;
      if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1 || fifo.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL fifo_wait_payload: got valid=%b s_ready=%b fifo=%0d, required valid=0 s_ready=1 fifo=0",
                  m_axis_tvalid, s_axis_tready, fifo.size());
      end
      m_axis_tready = 1'b0;
      @(posedge aclk);
      #1;
   endtask

   task automatic test_mid_frame_reset();
      logic [WIDTH-1:0] w[$];
      int               k     = 0;
      logic             found = 1'b0;
      do_reset();
      for (int i = 0; i < LENGTH; i++) w.push_back(WIDTH'(10 + i));
      model_push(w);
      run_stream(w, 100, 100, 50);
      got_q.delete();
      for (int c = 0; c < 20 && !found; c++) begin
         if (m_axis_tvalid && m_axis_tdata == WIDTH'(101)) begin
            found = 1'b1;
         end else begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = WIDTH'(100 + k);
            m_axis_tready = 1'b1;
            #1;
            if (m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tlast, m_axis_tdata});
            if (s_axis_tready) k++;
            @(posedge aclk);
            #1;
         end
      end
      vectors++;
      if (!found || got_q.size() != 3 || got_q[0] !== {1'b0, SYNC} || got_q[1] !== {1'b0, 32'h1}
          || got_q[2] !== {1'b0, 32'd100}) begin
         miscompares++;
         $display("[TB] FAIL mid_prefix: got found=%b words=%0d, required found=1 words=3 (SYNC, seq 1, 100)",
                  found, got_q.size());
      end
      areset = 1'b1;
      #1;
      vectors++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, s_axis_tready} !== {2'b00, 32'h0, 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL mid_reset_clear: got valid=%b last=%b data=%h s_ready=%b, required all zero",
                  m_axis_tvalid, m_axis_tlast, m_axis_tdata, s_axis_tready);
      end
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b0;
      @(posedge aclk);
      #1 areset = 1'b0;
      model_seq = 16'h0;
      exp_q.delete();
      w.delete();
      for (int i = 0; i < LENGTH; i++) w.push_back(WIDTH'($urandom));
      model_push(w);
      run_stream(w, 100, 100, 50);
      vectors++;
      if (got_q.size() != exp_q.size()) begin
         miscompares++;
         $display("[TB] FAIL mid_after_count: got %0d words, required %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         vectors++;
         if (got_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("[TB] FAIL mid_after_word[%0d]: got last=%b data=%h, required last=%b data=%h",
                     i, got_q[i][WIDTH], got_q[i][WIDTH-1:0], exp_q[i][WIDTH], exp_q[i][WIDTH-1:0]);
         end
      end
   endtask

   // Preloading seq to 16'hFFFF stands in for running 65535 frames.
   task automatic test_seq_wrap();
      logic [WIDTH-1:0] w[$];
      do_reset();
      force dut.seq = 16'hFFFF;
      @(posedge aclk);
      #1;
      release dut.seq;
      model_seq = 16'hFFFF;
      exp_q.delete();
      for (int i = 0; i < 2 * LENGTH; i++) w.push_back(WIDTH'($urandom));
      model_push(w);
      run_stream(w, 100, 100, 60);
      vectors++;
      if (got_q.size() != exp_q.size()) begin
         miscompares++;
         $display("[TB] FAIL wrap_count: got %0d words, required %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         vectors++;
         if (got_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("[TB] FAIL wrap_word[%0d]: got last=%b data=%h, required last=%b data=%h",
                     i, got_q[i][WIDTH], got_q[i][WIDTH-1:0], exp_q[i][WIDTH], exp_q[i][WIDTH-1:0]);
         end
      end
      if (got_q.size() > LENGTH + 3) begin
         vectors++;
         if (got_q[1] !== {1'b0, 32'h0000FFFF} || got_q[LENGTH+3] !== {1'b0, 32'h0}) begin
            miscompares++;
            $display("[TB] FAIL wrap_seq: got %h then %h, required 0000ffff then 00000000",
                     got_q[1][WIDTH-1:0], got_q[LENGTH+3][WIDTH-1:0]);
         end
      end
   endtask

   initial begin
      areset        = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      m_axis_tready = 1'b0;
      model_seq     = 16'h0;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_backpressure();
      test_chained_fifo();
      test_mid_frame_reset();
      test_seq_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
